// File: rtl/tlc_pkg.sv
// Shared definitions for the traffic-light controller and its phase timer.
package tlc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RED    = 2'b01,
        GREEN  = 2'b10,
        YELLOW = 2'b11
    } tlc_state_t;

    localparam int DEFAULT_TICK_DIV    = 125000000;
    localparam int DEFAULT_RED_TIME    = 9;
    localparam int DEFAULT_GREEN_TIME  = 7;
    localparam int DEFAULT_YELLOW_TIME = 3;

    // Duration in seconds for a given phase; IDLE has no duration.
    function automatic logic [3:0] phase_duration(
        input tlc_state_t st,
        input logic [3:0] red_t,
        input logic [3:0] green_t,
        input logic [3:0] yellow_t
    );
        logic [3:0] dur;
        dur = 4'd0;
        case (st)
            RED:     dur = red_t;
            GREEN:   dur = green_t;
            YELLOW:  dur = yellow_t;
            default: dur = 4'd0;
        endcase
        return dur;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clocks,
// restartable from zero with a synchronous clear.
module tick_prescaler #(
    parameter int TICK_DIV = 125000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    // Count 0..TICK_DIV-1 and wrap; clear restarts the period from zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/phase_timer.sv
// Per-phase countdown timer: reloads on every controller phase change,
// counts down once per second and pulses timer_done on expiry.
module phase_timer
    import tlc_pkg::*;
#(
    parameter int TICK_DIV    = DEFAULT_TICK_DIV,
    parameter int RED_TIME    = DEFAULT_RED_TIME,
    parameter int GREEN_TIME  = DEFAULT_GREEN_TIME,
    parameter int YELLOW_TIME = DEFAULT_YELLOW_TIME
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] state,
    output logic [3:0] timer_value,
    output logic       timer_done,
    output logic       sec_tick
);

    // Durations must fit the 4-bit display and be non-zero; divider must be >= 2.
    generate
        if (RED_TIME < 1 || RED_TIME > 15 ||
            GREEN_TIME < 1 || GREEN_TIME > 15 ||
            YELLOW_TIME < 1 || YELLOW_TIME > 15) begin : g_bad_duration
            $error("phase_timer: phase durations must be in 1..15");
        end
        if (TICK_DIV < 2) begin : g_bad_div
            $error("phase_timer: TICK_DIV must be at least 2");
        end
    endgenerate

    localparam logic [3:0] RED_DUR    = 4'(RED_TIME);
    localparam logic [3:0] GREEN_DUR  = 4'(GREEN_TIME);
    localparam logic [3:0] YELLOW_DUR = 4'(YELLOW_TIME);

    tlc_state_t state_cur;
    tlc_state_t state_q;
    logic       is_idle;
    logic       change;
    logic       clear;
    logic       tick;
    logic [3:0] load_value;

    assign state_cur  = tlc_state_t'(state);
    assign is_idle    = (state_cur == IDLE);
    assign change     = (state_cur != state_q);
    assign clear      = is_idle | change;
    assign load_value = phase_duration(state_cur, RED_DUR, GREEN_DUR, YELLOW_DUR);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .tick  (tick)
    );

    // Track the last seen phase so a change triggers a reload; re-time the tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            sec_tick <= 1'b0;
        end else begin
            state_q  <= state_cur;
            sec_tick <= tick;
        end
    end

    // Countdown: IDLE clears, reload beats tick, then decrement with a done pulse at 1->0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_value <= 4'd0;
            timer_done  <= 1'b0;
        end else if (is_idle) begin
            timer_value <= 4'd0;
            timer_done  <= 1'b0;
        end else if (change) begin
            timer_value <= load_value;
            timer_done  <= 1'b0;
        end else if (tick && timer_value > 4'd1) begin
            timer_value <= timer_value - 4'd1;
            timer_done  <= 1'b0;
        end else if (tick && timer_value == 4'd1) begin
            timer_value <= 4'd0;
            timer_done  <= 1'b1;
        end else begin
            timer_done  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_phase_timer.sv
// Randomised and directed bench for phase_timer against a behavioural model.
module tb_phase_timer;

    localparam int TD       = 4;
    localparam int RED_T    = 5;
    localparam int GREEN_T  = 4;
    localparam int YELLOW_T = 2;

    localparam logic [1:0] S_IDLE   = 2'b00;
    localparam logic [1:0] S_RED    = 2'b01;
    localparam logic [1:0] S_GREEN  = 2'b10;
    localparam logic [1:0] S_YELLOW = 2'b11;

    logic       clk;
    logic       reset;
    logic [1:0] state;
    logic [3:0] timer_value;
    logic       timer_done;
    logic       sec_tick;

    int checks;
    int errors;

    // Behavioural model: cycles since the last prescaler restart, remaining seconds.
    int m_cnt;
    int m_val;
    int m_done;
    int m_sec;
    int m_prev;

    phase_timer #(
        .TICK_DIV    (TD),
        .RED_TIME    (RED_T),
        .GREEN_TIME  (GREEN_T),
        .YELLOW_TIME (YELLOW_T)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .state       (state),
        .timer_value (timer_value),
        .timer_done  (timer_done),
        .sec_tick    (sec_tick)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case anything hangs.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic int durOf(input int st);
        case (st)
            1: return RED_T;
            2: return GREEN_T;
            3: return YELLOW_T;
            default: return 0;
        endcase
    endfunction

    function automatic logic [1:0] nextPhase(input logic [1:0] st);
        case (st)
            S_RED:   return S_GREEN;
            S_GREEN: return S_YELLOW;
            default: return S_RED;
        endcase
    endfunction

    task automatic modelReset();
        m_cnt  = 0;
        m_val  = 0;
        m_done = 0;
        m_sec  = 0;
        m_prev = 0;
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic modelEdge();
        bit tk;
        if (reset) begin
            modelReset();
            return;
        end
        tk    = ((m_cnt % TD) == TD - 1);
        m_sec = tk ? 1 : 0;
        if (int'(state) == 0) begin
            m_val  = 0;
            m_done = 0;
            m_cnt  = 0;
        end else if (int'(state) != m_prev) begin
            m_val  = durOf(int'(state));
            m_done = 0;
            m_cnt  = 0;
        end else begin
            m_cnt++;
            m_done = 0;
            if (tk && m_val > 0) begin
                m_val--;
                m_done = (m_val == 0) ? 1 : 0;
            end
        end
        m_prev = int'(state);
    endtask

    task automatic stepCycle();
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput("timer_value", int'(timer_value), m_val);
        checkOutput("timer_done", int'(timer_done), m_done);
        checkOutput("sec_tick", int'(sec_tick), m_sec);
    endtask

    task automatic applyStimulus(input logic [1:0] st, input int cycles);
        state = st;
        repeat (cycles) stepCycle();
    endtask

    task automatic waitValue(input int target, input string tag);
        int n;
        n = 0;
        while (int'(timer_value) != target && n < 40) begin
            stepCycle();
            n++;
        end
        if (n >= 40) checkOutput(tag, int'(timer_value), target);
    endtask

    initial begin
        int done_at;
        int sec_cnt;
        int done_cnt;
        int d_idx;
        int dones;
        int reloads;
        int prev_done;
        int n;
        logic [1:0] cur;

        checks = 0;
        errors = 0;
        modelReset();

        // Reset held with RED requested: everything stays quiet.
        reset = 1'b1;
        state = S_RED;
        repeat (3) stepCycle();
        checkOutput("reset_value", int'(timer_value), 0);
        checkOutput("reset_done", int'(timer_done), 0);

        // Release: first edge loads RED, done pulse 20 cycles after reload.
        reset = 1'b0;
        stepCycle();
        checkOutput("first_load", int'(timer_value), RED_T);
        done_at = -1;
        for (int i = 1; i <= 30 && done_at < 0; i++) begin
            stepCycle();
            if (timer_done) done_at = i;
        end
        checkOutput("done_latency", done_at, RED_T * TD);

        // Controller stalled in RED: value stays 0, no done, sec_tick keeps going.
        sec_cnt  = 0;
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            stepCycle();
            if (sec_tick) sec_cnt++;
            if (timer_done) done_cnt++;
        end
        checkOutput("stall_sec_ticks", sec_cnt, 12 / TD);
        checkOutput("stall_dones", done_cnt, 0);
        checkOutput("stall_value", int'(timer_value), 0);

        // Full loop driven by a registered controller model.
        applyStimulus(S_IDLE, 2);
        cur       = S_RED;
        state     = cur;
        d_idx     = -1;
        dones     = 0;
        reloads   = 0;
        prev_done = 0;
        for (int i = 0; i < 160; i++) begin
            stepCycle();
            if (prev_done != 0) begin
                cur   = nextPhase(cur);
                state = cur;
            end
            if (d_idx >= 0 && timer_value != 4'd0) begin
                checkOutput("done_to_reload", i - d_idx, 2);
                checkOutput("reload_value", int'(timer_value), durOf(int'(cur)));
                d_idx = -1;
                reloads++;
            end
            if (timer_done) begin
                d_idx = i;
                dones++;
            end
            prev_done = timer_done ? 1 : 0;
        end
        checkOutput("loop_dones_vs_reloads", dones, reloads);
        checkOutput("loop_reloads", reloads, 9);

        // Abort to IDLE mid-countdown, then restart RED.
        applyStimulus(S_IDLE, 2);
        state = S_RED;
        waitValue(3, "wait_val3_abort");
        state = S_IDLE;
        stepCycle();
        checkOutput("abort_value", int'(timer_value), 0);
        checkOutput("abort_done", int'(timer_done), 0);
        applyStimulus(S_IDLE, 3);
        applyStimulus(S_RED, 1);
        checkOutput("restart_value", int'(timer_value), RED_T);

        // GREEN -> YELLOW on the same edge as a tick: reload wins.
        applyStimulus(S_GREEN, 1);
        n = 0;
        while (!((m_cnt % TD) == TD - 1 && m_val > 1) && n < 20) begin
            stepCycle();
            n++;
        end
        checkOutput("wait_tick_edge", n < 20 ? 1 : 0, 1);
        state = S_YELLOW;
        stepCycle();
        checkOutput("reload_wins", int'(timer_value), YELLOW_T);
        for (int i = 0; i < TD - 1; i++) begin
            stepCycle();
            checkOutput("hold_after_reload", int'(timer_value), YELLOW_T);
        end
        stepCycle();
        checkOutput("first_decrement", int'(timer_value), YELLOW_T - 1);

        // Asynchronous reset in the middle of a cycle while counting.
        applyStimulus(S_IDLE, 2);
        state = S_RED;
        waitValue(3, "wait_val3_reset");
        #2;
        reset = 1'b1;
        modelReset();
        #1;
        checkOutput("async_value", int'(timer_value), 0);
        checkOutput("async_done", int'(timer_done), 0);
        checkOutput("async_sec", int'(sec_tick), 0);
        stepCycle();
        reset = 1'b0;
        stepCycle();
        checkOutput("post_reset_load", int'(timer_value), RED_T);

        // Random phase changes and occasional reset pulses.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) state = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) begin
                reset = 1'b1;
                modelReset();
                #1;
                checkOutput("rand_async_value", int'(timer_value), 0);
                stepCycle();
                reset = 1'b0;
            end
            stepCycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
